// File: rtl/n_term_cfg_pkg.sv
// n_term_cfg_pkg: shared types and constants for the north-terminal switch matrix.
//   state_t  - configuration FSM states (IDLE, SHIFT, COMMIT)
//   SEL_*    - per-output route select codes
//   SEL_W    - select bits per output
package n_term_cfg_pkg;

  localparam int SEL_W = 2;

  localparam logic [SEL_W-1:0] SEL_PASS = 2'd0;
  localparam logic [SEL_W-1:0] SEL_ROT  = 2'd1;
  localparam logic [SEL_W-1:0] SEL_ZERO = 2'd2;
  localparam logic [SEL_W-1:0] SEL_ONE  = 2'd3;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    COMMIT = 2'd2
  } state_t;

endpackage : n_term_cfg_pkg

// File: rtl/n_term_route_mux.sv
// n_term_route_mux: single-output 4:1 route mux.
// Ports:
//   pass_in   in   own input wire (passthrough source)
//   rot_in    in   next lane of the same channel (rotate source)
//   sel       in   route select (SEL_PASS/SEL_ROT/SEL_ZERO/SEL_ONE)
//   route_out out  routed value
module n_term_route_mux
  import n_term_cfg_pkg::*;
(
  input  logic             pass_in,
  input  logic             rot_in,
  input  logic [SEL_W-1:0] sel,
  output logic             route_out
);

  // Select the routed value for this output.
  always_comb begin
    route_out = 1'b0;
    case (sel)
      SEL_PASS: route_out = pass_in;
      SEL_ROT:  route_out = rot_in;
      SEL_ZERO: route_out = 1'b0;
      SEL_ONE:  route_out = 1'b1;
      default:  route_out = pass_in;
    endcase
  end

endmodule : n_term_route_mux

// File: rtl/n_term_cfg_switch_matrix.sv
// n_term_cfg_switch_matrix: north-terminal switch matrix with a serially loaded,
// atomically committed route table. Reset state is pure passthrough.
// Optional feature macro: N_TERM_CFG_SWITCH_MATRIX_PIPE_EN (registers to_S, latency 1).
// Ports:
//   UserCLK    in   fabric clock
//   UserRST_n  in   asynchronous active-low reset
//   from_N     in   CHANNELS*LANES input wires, index c*LANES+l
//   to_S       out  CHANNELS*LANES output wires, same indexing
//   cfg_start  in   begin a table load (IDLE only)
//   cfg_abort  in   abandon a load in progress (SHIFT only)
//   cfg_valid  in   cfg_bit valid this cycle
//   cfg_bit    in   serial config data, MSB first
//   cfg_ready  out  high in SHIFT
//   cfg_done   out  one-cycle pulse in COMMIT
//   cfg_busy   out  high in SHIFT or COMMIT
module n_term_cfg_switch_matrix
  import n_term_cfg_pkg::*;
#(
  parameter int CHANNELS = 8,
  parameter int LANES    = 2
) (
  input  logic                      UserCLK,
  input  logic                      UserRST_n,
  input  logic [CHANNELS*LANES-1:0] from_N,
  output logic [CHANNELS*LANES-1:0] to_S,
  input  logic                      cfg_start,
  input  logic                      cfg_abort,
  input  logic                      cfg_valid,
  input  logic                      cfg_bit,
  output logic                      cfg_ready,
  output logic                      cfg_done,
  output logic                      cfg_busy
);

  localparam int N     = CHANNELS * LANES;
  localparam int TOT   = N * SEL_W;
  localparam int CNT_W = $clog2(TOT + 1);

  state_t           state_r;
  logic [CNT_W-1:0] cnt_r;
  logic [TOT-1:0]   shadow_r;
  logic [TOT-1:0]   active_r;
  logic             ready_r;
  logic             done_r;
  logic             busy_r;
  logic [N-1:0]     route_s;
  logic             accept_s;

  assign accept_s  = cfg_valid & ready_r;
  assign cfg_ready = ready_r;
  assign cfg_done  = done_r;
  assign cfg_busy  = busy_r;

  // Config FSM: shift into shadow, commit shadow to active in one cycle.
  // Status outputs are registered alongside the state they describe.
  always_ff @(posedge UserCLK or negedge UserRST_n) begin
    if (!UserRST_n) begin
      state_r  <= IDLE;
      cnt_r    <= '0;
      shadow_r <= '0;
      active_r <= '0;
      ready_r  <= 1'b0;
      done_r   <= 1'b0;
      busy_r   <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          done_r <= 1'b0;
          if (cfg_start) begin
            state_r <= SHIFT;
            cnt_r   <= '0;
            ready_r <= 1'b1;
            busy_r  <= 1'b1;
          end else begin
            ready_r <= 1'b0;
            busy_r  <= 1'b0;
          end
        end
        SHIFT: begin
          // Abort takes priority over a simultaneous final accept.
          if (cfg_abort) begin
            state_r <= IDLE;
            cnt_r   <= '0;
            ready_r <= 1'b0;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
          end else if (accept_s) begin
            shadow_r <= {shadow_r[TOT-2:0], cfg_bit};
            if (cnt_r == CNT_W'(TOT - 1)) begin
              state_r <= COMMIT;
              cnt_r   <= CNT_W'(TOT);
              ready_r <= 1'b0;
              done_r  <= 1'b1;
            end else begin
              cnt_r <= cnt_r + CNT_W'(1);
            end
          end else begin
            state_r <= SHIFT;
          end
        end
        COMMIT: begin
          active_r <= shadow_r;
          state_r  <= IDLE;
          cnt_r    <= '0;
          done_r   <= 1'b0;
          busy_r   <= 1'b0;
          ready_r  <= 1'b0;
        end
        default: begin
          state_r <= IDLE;
          cnt_r   <= '0;
          ready_r <= 1'b0;
          done_r  <= 1'b0;
          busy_r  <= 1'b0;
        end
      endcase
    end
  end

  // One route mux per output; the rotate source is the next lane of the same
  // channel, which collapses to the own wire when LANES==1.
  for (genvar c = 0; c < CHANNELS; c++) begin : g_chan
    for (genvar l = 0; l < LANES; l++) begin : g_lane
      localparam int I = c * LANES + l;
      localparam int R = c * LANES + ((l + 1) % LANES);
      n_term_route_mux u_mux (
        .pass_in  (from_N[I]),
        .rot_in   (from_N[R]),
        .sel      (active_r[SEL_W*I +: SEL_W]),
        .route_out(route_s[I])
      );
    end
  end

`ifdef N_TERM_CFG_SWITCH_MATRIX_PIPE_EN
  logic [N-1:0] pipe_r;

  // Output pipe stage: to_S lags the route result by one clock.
  always_ff @(posedge UserCLK or negedge UserRST_n) begin
    if (!UserRST_n) begin
      pipe_r <= '0;
    end else begin
      pipe_r <= route_s;
    end
  end

  assign to_S = pipe_r;
`else
  assign to_S = route_s;
`endif

endmodule : n_term_cfg_switch_matrix

// File: tb/tb_n_term_cfg_switch_matrix.sv
// Directed self-checking bench for n_term_cfg_switch_matrix (CHANNELS=8, LANES=2).
module tb_n_term_cfg_switch_matrix;

  logic        clk;
  logic        rst_n;
  logic [15:0] from_n;
  logic [15:0] to_s;
  logic        cfg_start;
  logic        cfg_abort;
  logic        cfg_valid;
  logic        cfg_bit;
  logic        cfg_ready;
  logic        cfg_done;
  logic        cfg_busy;

  int tests;
  int fails;

  n_term_cfg_switch_matrix #(.CHANNELS(8), .LANES(2)) dut (
    .UserCLK  (clk),
    .UserRST_n(rst_n),
    .from_N   (from_n),
    .to_S     (to_s),
    .cfg_start(cfg_start),
    .cfg_abort(cfg_abort),
    .cfg_valid(cfg_valid),
    .cfg_bit  (cfg_bit),
    .cfg_ready(cfg_ready),
    .cfg_done (cfg_done),
    .cfg_busy (cfg_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Start a load and feed n bits of data MSB first; returns at the negedge
  // right after the last accepted bit.
  task automatic load(input logic [31:0] data, input int n, input bit gaps,
                      input bit check_hold, input logic [15:0] hold_exp);
    @(negedge clk) cfg_start = 1'b1;
    @(negedge clk) cfg_start = 1'b0;
    for (int i = 0; i < n; i++) begin
      if (i == 0) check("ready_in_shift", {31'd0, cfg_ready}, 32'd1);
      if (check_hold && i == 16) check("to_s_hold_mid_shift", {16'd0, to_s}, {16'd0, hold_exp});
      cfg_valid = 1'b1;
      cfg_bit   = data[31-i];
      @(negedge clk);
      if (gaps && (i % 3 == 0)) begin
        cfg_valid = 1'b0;
        @(negedge clk);
      end
    end
    cfg_valid = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    tests = 0;
    fails = 0;
    rst_n = 1'b0;
    from_n = 16'hA5C3;
    cfg_start = 1'b0;
    cfg_abort = 1'b0;
    cfg_valid = 1'b0;
    cfg_bit = 1'b0;

    // Reset state
    #12;
    check("busy_in_reset", {31'd0, cfg_busy}, 32'd0);
`ifdef N_TERM_CFG_SWITCH_MATRIX_PIPE_EN
    check("to_s_in_reset", {16'd0, to_s}, 32'h0000);
`else
    check("to_s_in_reset", {16'd0, to_s}, 32'hA5C3);
`endif
    @(negedge clk) rst_n = 1'b1;
    @(negedge clk);
    check("to_s_after_reset", {16'd0, to_s}, 32'hA5C3);
    check("ready_after_reset", {31'd0, cfg_ready}, 32'd0);
    check("busy_after_reset", {31'd0, cfg_busy}, 32'd0);
    check("done_after_reset", {31'd0, cfg_done}, 32'd0);

    // All outputs rotate
    load(32'h5555_5555, 32, 1'b0, 1'b1, 16'hA5C3);
    check("done_pulse", {31'd0, cfg_done}, 32'd1);
    check("busy_commit", {31'd0, cfg_busy}, 32'd1);
    check("ready_commit", {31'd0, cfg_ready}, 32'd0);
    from_n = 16'h0001;
    @(negedge clk);
    check("done_one_cycle", {31'd0, cfg_done}, 32'd0);
    check("busy_after_commit", {31'd0, cfg_busy}, 32'd0);
    @(negedge clk);
    check("rot_0001", {16'd0, to_s}, 32'h0002);
    from_n = 16'h8000;
    @(negedge clk);
    check("rot_8000", {16'd0, to_s}, 32'h4000);

    // Ties: upper outputs 0, lower outputs 1; table holds during shift
    from_n = 16'h1234;
    load(32'hAAAA_FFFF, 32, 1'b0, 1'b1, 16'h2138);
    check("done_pulse_tie", {31'd0, cfg_done}, 32'd1);
    @(negedge clk);
    @(negedge clk);
    check("tie_1234", {16'd0, to_s}, 32'h00FF);
    from_n = 16'hFFFF;
    @(negedge clk);
    check("tie_ffff", {16'd0, to_s}, 32'h00FF);
    from_n = 16'h0000;
    @(negedge clk);
    check("tie_0000", {16'd0, to_s}, 32'h00FF);

    // Abort after 20 gapped bits
    from_n = 16'h5A5A;
    load(32'h0F0F_0000, 20, 1'b1, 1'b0, 16'h0000);
    check("busy_before_abort", {31'd0, cfg_busy}, 32'd1);
    cfg_abort = 1'b1;
    @(negedge clk) cfg_abort = 1'b0;
    check("abort_busy", {31'd0, cfg_busy}, 32'd0);
    check("abort_ready", {31'd0, cfg_ready}, 32'd0);
    check("abort_done", {31'd0, cfg_done}, 32'd0);
    @(negedge clk);
    check("abort_done_later", {31'd0, cfg_done}, 32'd0);
    check("abort_table_kept", {16'd0, to_s}, 32'h00FF);

    // Abort simultaneous with the final accept wins
    load(32'h0000_0000, 31, 1'b0, 1'b0, 16'h0000);
    cfg_valid = 1'b1;
    cfg_bit = 1'b0;
    cfg_abort = 1'b1;
    @(negedge clk);
    cfg_valid = 1'b0;
    cfg_abort = 1'b0;
    check("abort_final_busy", {31'd0, cfg_busy}, 32'd0);
    check("abort_final_done", {31'd0, cfg_done}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    check("abort_final_table", {16'd0, to_s}, 32'h00FF);

    // Reset mid-load
    load(32'h5555_5555, 10, 1'b0, 1'b0, 16'h0000);
    #2 rst_n = 1'b0;
    #1;
    check("midload_rst_busy", {31'd0, cfg_busy}, 32'd0);
    check("midload_rst_ready", {31'd0, cfg_ready}, 32'd0);
`ifdef N_TERM_CFG_SWITCH_MATRIX_PIPE_EN
    check("midload_rst_to_s", {16'd0, to_s}, 32'h0000);
`else
    check("midload_rst_to_s", {16'd0, to_s}, 32'h5A5A);
`endif
    @(negedge clk) rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_pass", {16'd0, to_s}, 32'h5A5A);
    load(32'h5555_5555, 32, 1'b0, 1'b0, 16'h0000);
    check("post_rst_done", {31'd0, cfg_done}, 32'd1);
    @(negedge clk);
    @(negedge clk);
    check("post_rst_rot", {16'd0, to_s}, 32'hA5A5);

    // Output latency on a from_N step (table is all-rotate)
    from_n = 16'h0000;
    @(negedge clk);
    check("step_low", {16'd0, to_s}, 32'h0000);
    from_n = 16'hFFFF;
    #1;
`ifdef N_TERM_CFG_SWITCH_MATRIX_PIPE_EN
    check("step_before_edge", {16'd0, to_s}, 32'h0000);
`else
    check("step_before_edge", {16'd0, to_s}, 32'hFFFF);
`endif
    @(posedge clk) #1;
    check("step_after_edge", {16'd0, to_s}, 32'hFFFF);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule : tb_n_term_cfg_switch_matrix
